// File: rtl/util_io_pkg.sv
// Shared constants and helpers for the GPIO receive path.
package util_io_pkg;

    // Legal synchronizer depth range.
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // irq_edge encoding.
    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

    // Ceiling log2; clog2(0) and clog2(1) return 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/util_io_debounce.sv
// Single-bit pad synchronizer followed by a debounce counter.
// stable_next_o exposes the next stable value so the parent can register
// edge pulses in the same cycle the stable value changes.
module util_io_debounce
    import util_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    input  logic bypass_i,
    output logic stable_o,
    output logic stable_next_o
);

    localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Pure shift chain: nothing but wires between synchronizer stages.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        sync   = sync_q[SYNC_STAGES-1];
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (bypass_i) begin
            stable_d = sync;
        end else if (sync != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, stable level and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o      = stable_q;
    assign stable_next_o = stable_d;

endmodule

// File: rtl/util_io_recv.sv
// GPIO receive conditioner: per-bit sync + debounce, edge pulses, sticky
// maskable edge flags and a registered interrupt.
// Optional macro UTIL_IO_RECV_BYPASS_EN adds a per-bit debounce_bypass input.
module util_io_recv
    import util_io_pkg::*;
#(
    parameter int unsigned PORT_WIDTH      = 1,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_WIDTH-1:0] gpio_i,
`ifdef UTIL_IO_RECV_BYPASS_EN
    input  logic [PORT_WIDTH-1:0] debounce_bypass,
`endif
    output logic [PORT_WIDTH-1:0] s_gpio_i,
    output logic [PORT_WIDTH-1:0] rise_o,
    output logic [PORT_WIDTH-1:0] fall_o,
    input  logic [PORT_WIDTH-1:0] irq_en,
    input  logic [PORT_WIDTH-1:0] irq_edge,
    input  logic [PORT_WIDTH-1:0] irq_clr,
    output logic [PORT_WIDTH-1:0] irq_flag,
    output logic                  irq_o
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("util_io_recv: SYNC_STAGES out of range");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("util_io_recv: DEBOUNCE_CYCLES must be at least 1");
    end
    if (PORT_WIDTH < 1) begin : g_bad_width
        $error("util_io_recv: PORT_WIDTH must be at least 1");
    end

    logic [PORT_WIDTH-1:0] bypass;
    logic [PORT_WIDTH-1:0] stable, stable_next;
    logic [PORT_WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
    logic [PORT_WIDTH-1:0] flag_q, flag_d, flag_set;
    logic                  irq_q, irq_d;

`ifdef UTIL_IO_RECV_BYPASS_EN
    assign bypass = debounce_bypass;
`else
    assign bypass = '0;
`endif

    for (genvar b = 0; b < PORT_WIDTH; b++) begin : g_bit
        util_io_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk           (clk),
            .rst           (rst),
            .pad_i         (gpio_i[b]),
            .bypass_i      (bypass[b]),
            .stable_o      (stable[b]),
            .stable_next_o (stable_next[b])
        );
    end

    // Edge detect on the next stable value; set beats clear on the sticky flags.
    always_comb begin
        rise_d   = stable_next & ~stable;
        fall_d   = ~stable_next & stable;
        flag_set = '0;
        for (int b = 0; b < PORT_WIDTH; b++) begin
            flag_set[b] = (irq_edge[b] == EDGE_RISE) ? rise_d[b] : fall_d[b];
        end
        flag_d = (flag_q & ~irq_clr) | flag_set;
        irq_d  = |(flag_q & irq_en);
    end

    // Edge, flag and interrupt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            flag_q <= flag_d;
            irq_q  <= irq_d;
        end
    end

    assign s_gpio_i = stable;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign irq_flag = flag_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_util_io_recv.sv
// Self-checking bench for util_io_recv (PORT_WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=16).
// Edge pulses are checked against a queue of expected (cycle, bit, direction) events.
module tb_util_io_recv;

    localparam int PW  = 2;
    localparam int SS  = 2;
    localparam int DC  = 16;
    localparam int LAT = SS + DC;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] gpio_i, irq_en, irq_edge, irq_clr;
    logic [PW-1:0] s_gpio_i, rise_o, fall_o, irq_flag;
    logic          irq_o;
`ifdef UTIL_IO_RECV_BYPASS_EN
    logic [PW-1:0] debounce_bypass;
`endif

    util_io_recv #(
        .PORT_WIDTH      (PW),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gpio_i          (gpio_i),
`ifdef UTIL_IO_RECV_BYPASS_EN
        .debounce_bypass (debounce_bypass),
`endif
        .s_gpio_i        (s_gpio_i),
        .rise_o          (rise_o),
        .fall_o          (fall_o),
        .irq_en          (irq_en),
        .irq_edge        (irq_edge),
        .irq_clr         (irq_clr),
        .irq_flag        (irq_flag),
        .irq_o           (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int   cyc;
        int   bitn;
        logic rise;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int len;
        bit accept;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Edge monitor: every observed pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        for (int b = 0; b < PW; b++) begin
            if (rise_o[b] === 1'b1 || fall_o[b] === 1'b1) begin
                check("edge_exclusive", 32'(rise_o[b] & fall_o[b]), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_edge", 32'(rise_o[b] | fall_o[b]), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("edge_cycle", cyc, e.cyc);
                    check("edge_bit", b, e.bitn);
                    check("edge_dir", 32'(rise_o[b]), 32'(e.rise));
                    check("edge_level", 32'(s_gpio_i[b]), 32'(e.rise));
                end
            end
        end
    end

    initial begin
        int n;
        int m;
        vecs[0] = '{15, 1'b0};
        vecs[1] = '{16, 1'b1};
        vecs[2] = '{3,  1'b0};
        vecs[3] = '{1,  1'b0};
        vecs[4] = '{40, 1'b1};
        vecs[5] = '{17, 1'b1};

        rst      = 1'b1;
        gpio_i   = '0;
        irq_en   = '0;
        irq_edge = '0;
        irq_clr  = '0;
`ifdef UTIL_IO_RECV_BYPASS_EN
        debounce_bypass = 2'b10;
`endif
        ticks(3);
        check("rst_s_gpio", 32'(s_gpio_i), 0);
        check("rst_rise", 32'(rise_o), 0);
        check("rst_fall", 32'(fall_o), 0);
        check("rst_flag", 32'(irq_flag), 0);
        check("rst_irq", 32'(irq_o), 0);
        rst = 1'b0;
        tick();

        // Pulse-length table on bit 0, rising edges flagged.
        irq_edge = 2'b01;
        for (int v = 0; v < 6; v++) begin
            n = cyc;
            if (vecs[v].accept) exp_q.push_back('{n + LAT, 0, 1'b1});
            gpio_i[0] = 1'b1;
            ticks(vecs[v].len);
            m = cyc;
            gpio_i[0] = 1'b0;
            if (vecs[v].accept) exp_q.push_back('{m + LAT, 0, 1'b0});
            ticks(40);
            check("tbl_level", 32'(s_gpio_i[0]), 0);
            check("tbl_flag", 32'(irq_flag[0]), 32'(vecs[v].accept));
            irq_clr = 2'b01;
            tick();
            irq_clr = 2'b00;
            check("tbl_clr", 32'(irq_flag[0]), 0);
        end

        // Sticky flag with enabled interrupt.
        irq_en = 2'b01;
        n = cyc;
        exp_q.push_back('{n + LAT, 0, 1'b1});
        gpio_i[0] = 1'b1;
        ticks(LAT);
        check("st_flag", 32'(irq_flag[0]), 1);
        check("st_irq_lag", 32'(irq_o), 0);
        tick();
        check("st_irq", 32'(irq_o), 1);
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        check("st_clr_flag", 32'(irq_flag[0]), 0);
        check("st_clr_irq_lag", 32'(irq_o), 1);
        tick();
        check("st_clr_irq", 32'(irq_o), 0);
        m = cyc;
        exp_q.push_back('{m + LAT, 0, 1'b0});
        gpio_i[0] = 1'b0;
        ticks(30);
        check("st_fall_noflag", 32'(irq_flag[0]), 0);

        // Clear coincident with a new rise: set wins.
        n = cyc;
        exp_q.push_back('{n + LAT, 0, 1'b1});
        gpio_i[0] = 1'b1;
        ticks(LAT - 1);
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        check("coincide_flag", 32'(irq_flag[0]), 1);
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        check("coincide_clr", 32'(irq_flag[0]), 0);
        m = cyc;
        exp_q.push_back('{m + LAT, 0, 1'b0});
        gpio_i[0] = 1'b0;
        ticks(30);

        // Falling-edge selection with interrupt masked.
        irq_edge = 2'b00;
        irq_en   = 2'b00;
        n = cyc;
        exp_q.push_back('{n + LAT, 0, 1'b1});
        gpio_i[0] = 1'b1;
        ticks(30);
        check("fsel_rise_noflag", 32'(irq_flag[0]), 0);
        m = cyc;
        exp_q.push_back('{m + LAT, 0, 1'b0});
        gpio_i[0] = 1'b0;
        ticks(LAT);
        check("fsel_fall_flag", 32'(irq_flag[0]), 1);
        tick();
        check("fsel_masked_irq", 32'(irq_o), 0);
        irq_en = 2'b01;
        tick();
        check("fsel_en_irq", 32'(irq_o), 1);
        irq_en = 2'b00;
        tick();
        check("fsel_dis_irq", 32'(irq_o), 0);
        check("fsel_dis_flag", 32'(irq_flag[0]), 1);
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        check("fsel_clr", 32'(irq_flag[0]), 0);

        // Reset in the middle of a debounce window.
        irq_edge = 2'b01;
        irq_en   = 2'b01;
        gpio_i[0] = 1'b1;
        ticks(12);
        rst = 1'b1;
        tick();
        check("mrst_s_gpio", 32'(s_gpio_i), 0);
        check("mrst_flag", 32'(irq_flag), 0);
        check("mrst_irq", 32'(irq_o), 0);
        rst = 1'b0;
        n = cyc;
        exp_q.push_back('{n + LAT, 0, 1'b1});
        ticks(LAT - 1);
        check("mrst_not_yet", 32'(s_gpio_i[0]), 0);
        ticks(3);
        check("mrst_level", 32'(s_gpio_i[0]), 1);
        check("mrst_irq_after", 32'(irq_o), 1);
        m = cyc;
        exp_q.push_back('{m + LAT, 0, 1'b0});
        gpio_i[0] = 1'b0;
        ticks(30);
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        irq_en = 2'b00;

`ifdef UTIL_IO_RECV_BYPASS_EN
        // Bypassed bit follows the synchronizer with no debounce.
        irq_edge = 2'b10;
        n = cyc;
        exp_q.push_back('{n + SS + 1, 1, 1'b1});
        exp_q.push_back('{n + SS + 4, 1, 1'b0});
        gpio_i[1] = 1'b1;
        ticks(3);
        gpio_i[1] = 1'b0;
        ticks(10);
        check("byp_level", 32'(s_gpio_i[1]), 0);
        check("byp_flag", 32'(irq_flag[1]), 1);
`endif

        ticks(5);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
